// File: rtl/fir_sample_controller.sv
// ---------------------------------------------------------------------------
// fir_sample_controller
//
// Moore controller that sequences a 4-tap FIR datapath (16-entry register
// file plus multiplier/adder) and a 1000-sample counter.
//   * lc pulses load coefficients F0..F3 into R6..R9 (LC0 also clears the
//     sample counter).
//   * each dr pulse stores a new sample into R5, shifts the history R1..R4,
//     and accumulates R0 = +R1*F0 - R2*F1 + R3*F2 - R4*F3.
//   * a datapath overflow or a dr that drops before the store completes
//     parks the FSM in EIDLE with err asserted.
//
// Register map: R0 accumulator, R1..R4 sample history (R1 oldest),
//               R5 new sample, R6..R9 coefficients, R10 product temp.
//
// Optional feature: define ONE_K_AUTOCLR_EN to add a RESTART state that
// clears the sample counter after the sample on which one_k_samples is set.
// Without it, one_k_samples is ignored.
//
// Ports:
//   clk            system clock, rising edge
//   n_reset        synchronous active-low reset
//   dr             data ready (sample on datapath input bus)
//   lc             load coefficient (coefficient on datapath input bus)
//   overflow       datapath overflow for the op presented this cycle
//   one_k_samples  rollover flag from the sample counter
//   cnt_up         one-cycle count enable to the sample counter
//   clear          one-cycle synchronous clear to the sample counter
//   modwait        registered busy flag to the host
//   err            high while in EIDLE
//   op             datapath opcode (NOP/COPY/LOAD1/LOAD2/ADD/SUB/MUL)
//   src1, src2     operand register selects
//   dest           destination register select
// ---------------------------------------------------------------------------
module fir_sample_controller #(
    parameter int OP_W  = 3,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             dr,
    input  logic             lc,
    input  logic             overflow,
    input  logic             one_k_samples,
    output logic             cnt_up,
    output logic             clear,
    output logic             modwait,
    output logic             err,
    output logic [OP_W-1:0]  op,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest
);

    // Datapath opcodes
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_COPY  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD1 = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LOAD2 = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);

    // Register file indices
    localparam logic [REG_W-1:0] R_ACC  = REG_W'(0);
    localparam logic [REG_W-1:0] R_H1   = REG_W'(1);
    localparam logic [REG_W-1:0] R_H2   = REG_W'(2);
    localparam logic [REG_W-1:0] R_H3   = REG_W'(3);
    localparam logic [REG_W-1:0] R_H4   = REG_W'(4);
    localparam logic [REG_W-1:0] R_NEW  = REG_W'(5);
    localparam logic [REG_W-1:0] R_F0   = REG_W'(6);
    localparam logic [REG_W-1:0] R_F1   = REG_W'(7);
    localparam logic [REG_W-1:0] R_F2   = REG_W'(8);
    localparam logic [REG_W-1:0] R_F3   = REG_W'(9);
    localparam logic [REG_W-1:0] R_PROD = REG_W'(10);

    typedef enum logic [4:0] {
        IDLE,
        LC0, WAIT0, LC1, WAIT1, LC2, WAIT2, LC3,
        STORE, ZERO,
        SORT1, SORT2, SORT3, SORT4,
        MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
        EIDLE,
        RESTART
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   modwait_q;
    logic   modwait_d;

    // Host-visible busy classification; everything that is not a resting
    // state keeps the host off the bus.
    function automatic logic is_busy(input state_t s);
        return !(s inside {IDLE, WAIT0, WAIT1, WAIT2, EIDLE});
    endfunction

`ifndef ONE_K_AUTOCLR_EN
    logic unused_one_k;
    assign unused_one_k = one_k_samples;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lc)      state_d = LC0;
                else if (dr) state_d = STORE;
            end
            LC0:   state_d = WAIT0;
            LC1:   state_d = WAIT1;
            LC2:   state_d = WAIT2;
            LC3:   state_d = IDLE;
            // dr is deliberately ignored until all four coefficients land
            WAIT0: if (lc) state_d = LC1;
            WAIT1: if (lc) state_d = LC2;
            WAIT2: if (lc) state_d = LC3;
            // A dr that is gone by the end of STORE means the sample was lost
            STORE: state_d = dr ? ZERO : EIDLE;
            ZERO:  state_d = SORT1;
            SORT1: state_d = SORT2;
            SORT2: state_d = SORT3;
            SORT3: state_d = SORT4;
            SORT4: state_d = MUL1;
            MUL1:  state_d = overflow ? EIDLE : ADD1;
            ADD1:  state_d = overflow ? EIDLE : MUL2;
            MUL2:  state_d = overflow ? EIDLE : SUB2;
            SUB2:  state_d = overflow ? EIDLE : MUL3;
            MUL3:  state_d = overflow ? EIDLE : ADD3;
            ADD3:  state_d = overflow ? EIDLE : MUL4;
            MUL4:  state_d = overflow ? EIDLE : SUB4;
            SUB4: begin
                if (overflow) begin
                    state_d = EIDLE;
                end else begin
`ifdef ONE_K_AUTOCLR_EN
                    state_d = one_k_samples ? RESTART : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            RESTART: state_d = IDLE;
            EIDLE: begin
                if (lc)      state_d = LC0;
                else if (dr) state_d = STORE;
            end
            default: state_d = IDLE;
        endcase
    end

    // modwait is registered from the upcoming state so the host sees busy
    // aligned with the state itself, with no combinational input path.
    always_comb begin
        modwait_d = is_busy(state_d);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            modwait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            modwait_q <= modwait_d;
        end
    end

    assign modwait = modwait_q;

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        cnt_up = 1'b0;
        clear  = 1'b0;
        err    = 1'b0;
        op     = OP_NOP;
        src1   = R_ACC;
        src2   = R_ACC;
        dest   = R_ACC;
        case (state_q)
            LC0: begin op = OP_LOAD2; dest = R_F0; clear = 1'b1; end
            LC1: begin op = OP_LOAD2; dest = R_F1; end
            LC2: begin op = OP_LOAD2; dest = R_F2; end
            LC3: begin op = OP_LOAD2; dest = R_F3; end
            STORE: begin op = OP_LOAD1; dest = R_NEW; cnt_up = 1'b1; end
            // R0 - R0 zeroes the accumulator without a dedicated opcode
            ZERO:  begin op = OP_SUB; end
            SORT1: begin op = OP_COPY; src1 = R_H2;  dest = R_H1; end
            SORT2: begin op = OP_COPY; src1 = R_H3;  dest = R_H2; end
            SORT3: begin op = OP_COPY; src1 = R_H4;  dest = R_H3; end
            SORT4: begin op = OP_COPY; src1 = R_NEW; dest = R_H4; end
            MUL1:  begin op = OP_MUL; src1 = R_H1; src2 = R_F0; dest = R_PROD; end
            ADD1:  begin op = OP_ADD; src2 = R_PROD; end
            MUL2:  begin op = OP_MUL; src1 = R_H2; src2 = R_F1; dest = R_PROD; end
            SUB2:  begin op = OP_SUB; src2 = R_PROD; end
            MUL3:  begin op = OP_MUL; src1 = R_H3; src2 = R_F2; dest = R_PROD; end
            ADD3:  begin op = OP_ADD; src2 = R_PROD; end
            MUL4:  begin op = OP_MUL; src1 = R_H4; src2 = R_F3; dest = R_PROD; end
            SUB4:  begin op = OP_SUB; src2 = R_PROD; end
            RESTART: begin clear = 1'b1; end
            EIDLE:   begin err = 1'b1; end
            default: begin end
        endcase
    end

endmodule
